// File: rtl/pa_pkg.sv
// pa_pkg: pipeline-stage payload types for the pa CPU.
//   if_stage_t : fetch -> decode beat (pc, 32-bit instruction word)
//   id_stage_t : decode -> execute payload, including operand-usage and
//                legality flags used by the hazard logic and execute
//   imm_sel_e  : which immediate format the decoder extracts
package pa_pkg;

  localparam int PA_XLEN = 32;

  typedef struct packed {
    logic [PA_XLEN-1:0] pc;
    logic [31:0]        instr;
  } if_stage_t;

  typedef struct packed {
    logic [PA_XLEN-1:0] pc;
    logic [PA_XLEN-1:0] imm;
    logic [4:0]         rs1;
    logic [4:0]         rs2;
    logic [4:0]         rd;
    logic [6:0]         opcode;
    logic [2:0]         funct3;
    logic [6:0]         funct7;
    logic               uses_rs1;
    logic               uses_rs2;
    logic               writes_rd;
    logic               illegal;
  } id_stage_t;

  typedef enum logic [2:0] {
    IMM_NONE,
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J
  } imm_sel_e;

endpackage

// File: rtl/riscv_pkg.sv
// riscv_pkg: base-ISA opcode constants and instruction-format views.
// The instr_u union overlays the R/I/S/U layouts on one 32-bit word so the
// decoder can pick fields by name. B and J immediates are scrambled across
// several fields and are assembled from raw bits instead.
package riscv_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef struct packed {
    logic [6:0] funct7;
    logic [4:0] rs2;
    logic [4:0] rs1;
    logic [2:0] funct3;
    logic [4:0] rd;
    logic [6:0] opcode;
  } r_type_t;

  typedef struct packed {
    logic [11:0] imm;
    logic [4:0]  rs1;
    logic [2:0]  funct3;
    logic [4:0]  rd;
    logic [6:0]  opcode;
  } i_type_t;

  typedef struct packed {
    logic [6:0] imm_hi;
    logic [4:0] rs2;
    logic [4:0] rs1;
    logic [2:0] funct3;
    logic [4:0] imm_lo;
    logic [6:0] opcode;
  } s_type_t;

  typedef struct packed {
    logic [19:0] imm;
    logic [4:0]  rd;
    logic [6:0]  opcode;
  } u_type_t;

  typedef union packed {
    r_type_t     r;
    i_type_t     i;
    s_type_t     s;
    u_type_t     u;
    logic [31:0] raw;
  } instr_u;

endpackage

// File: rtl/id_fifo.sv
// id_fifo: synchronous FIFO with push/pop/flush and a combinational head.
// Ports:
//   clk_i, rst_i      clock, synchronous active-high reset
//   flush_i           empties the FIFO; a simultaneous push is dropped
//   push_i, data_i    write a beat (ignored while full)
//   pop_i, data_o     data_o is the current head; pop_i advances it
//   full_o, empty_o   status, both derived only from registered pointers
// Pointers carry one extra bit so full and empty are distinguishable.
// The head must be readable in the same cycle it is decoded, so storage is
// a small register array rather than registered-read RAM.
module id_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wptr_q, wptr_d;
  logic [AW:0]      rptr_q, rptr_d;
  logic             do_push, do_pop;

  assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign empty_o = (wptr_q == rptr_q);
  assign data_o  = mem_q[rptr_q[AW-1:0]];

  assign do_push = push_i && !full_o && !flush_i;
  assign do_pop  = pop_i && !empty_o && !flush_i;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (flush_i) begin
      wptr_d = '0;
      rptr_d = '0;
    end else begin
      if (do_push) wptr_d = wptr_q + (AW+1)'(1);
      if (do_pop)  rptr_d = rptr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // Storage needs no reset: entries are only observed between push and pop.
  always_ff @(posedge clk_i) begin
    if (do_push && !rst_i) mem_q[wptr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/id_decode_pipe.sv
// id_decode_pipe: buffered, registered instruction decode stage.
// Ports:
//   clk_i, rst_i                    clock, synchronous active-high reset
//   fetch_valid_i/fetch_ready_o     fetch handshake; fetch_i = {pc, instr}
//   decode_valid_o/decode_ready_i   execute handshake; decode_o = decoded op
//   flush_i                         drop everything buffered and the output
//   wb_valid_i, wb_rd_i             writeback releasing a busy register
// Build option: define ID_SCOREBOARD_EN to track busy destination registers
// and stall read-after-write hazards at the FIFO head. Without it the
// writeback ports are ignored and the stage never stalls.
module id_decode_pipe
  import riscv_pkg::*;
  import pa_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int FIFO_DEPTH = 2,
  parameter int NUM_REGS   = 32
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        fetch_valid_i,
  output logic                        fetch_ready_o,
  input  if_stage_t                   fetch_i,
  output logic                        decode_valid_o,
  input  logic                        decode_ready_i,
  output id_stage_t                   decode_o,
  input  logic                        flush_i,
  input  logic                        wb_valid_i,
  input  logic [$clog2(NUM_REGS)-1:0] wb_rd_i
);

  localparam int FIFO_W = $bits(if_stage_t);

  logic [FIFO_W-1:0] head_bits;
  if_stage_t         head;
  logic              fifo_full, fifo_empty;
  logic              load, stall;
  id_stage_t         dec;
  logic              valid_q, valid_d;
  id_stage_t         decode_q, decode_d;

  assign fetch_ready_o = !fifo_full;
  assign head          = head_bits;

  id_fifo #(.WIDTH(FIFO_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (flush_i),
    .push_i  (fetch_valid_i),
    .data_i  (fetch_i),
    .pop_i   (load),
    .data_o  (head_bits),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Combinational decode of the FIFO head.
  always_comb begin
    instr_u            ins;
    imm_sel_e          sel;
    logic              legal, u1, u2, wr;
    logic [31:0]       imm32;
    logic [XLEN-1:0]   imm_x;
    ins   = head.instr;
    sel   = IMM_NONE;
    legal = 1'b1;
    u1    = 1'b0;
    u2    = 1'b0;
    wr    = 1'b0;
    if (ins.raw[1:0] != 2'b11) begin
      legal = 1'b0;
    end else begin
      case (ins.r.opcode)
        OPC_LUI, OPC_AUIPC: begin sel = IMM_U; wr = 1'b1; end
        OPC_JAL:            begin sel = IMM_J; wr = 1'b1; end
        OPC_JALR, OPC_LOAD, OPC_IMM: begin sel = IMM_I; u1 = 1'b1; wr = 1'b1; end
        OPC_STORE:          begin sel = IMM_S; u1 = 1'b1; u2 = 1'b1; end
        OPC_BRANCH:         begin sel = IMM_B; u1 = 1'b1; u2 = 1'b1; end
        OPC_OP:             begin u1 = 1'b1; u2 = 1'b1; wr = 1'b1; end
        default:            legal = 1'b0;
      endcase
    end
    case (sel)
      IMM_I:   imm32 = {{20{ins.raw[31]}}, ins.i.imm};
      IMM_S:   imm32 = {{20{ins.raw[31]}}, ins.s.imm_hi, ins.s.imm_lo};
      IMM_B:   imm32 = {{20{ins.raw[31]}}, ins.raw[7], ins.raw[30:25], ins.raw[11:8], 1'b0};
      IMM_U:   imm32 = {ins.u.imm, 12'h000};
      IMM_J:   imm32 = {{12{ins.raw[31]}}, ins.raw[19:12], ins.raw[20], ins.raw[30:21], 1'b0};
      default: imm32 = 32'h0;
    endcase
    // Every 32-bit form already carries instr[31] at bit 31; widen signed.
    imm_x = XLEN'($signed(imm32));

    dec           = '0;
    dec.pc        = head.pc;
    dec.rs1       = ins.r.rs1;
    dec.rs2       = ins.r.rs2;
    dec.rd        = ins.r.rd;
    dec.opcode    = ins.r.opcode;
    dec.funct3    = ins.r.funct3;
    dec.funct7    = ins.r.funct7;
    dec.illegal   = !legal;
    dec.imm       = legal ? PA_XLEN'(imm_x) : '0;
    dec.uses_rs1  = legal && u1;
    dec.uses_rs2  = legal && u2;
    dec.writes_rd = legal && wr && (ins.r.rd != 5'd0);
  end

`ifdef ID_SCOREBOARD_EN
  logic [NUM_REGS-1:0] busy_q, busy_d, clr_mask, busy_eff;

  // Bit 0 is tied low so x0 never stalls a reader.
  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_busy
    if (gi == 0) begin : g_x0
      assign clr_mask[gi] = 1'b0;
      assign busy_d[gi]   = 1'b0;
    end else begin : g_xn
      logic set_bit;
      assign clr_mask[gi] = wb_valid_i && (wb_rd_i == ($clog2(NUM_REGS))'(gi));
      assign set_bit      = load && dec.writes_rd && (dec.rd == 5'(gi));
      // Set beats a same-cycle clear of the same register.
      assign busy_d[gi]   = set_bit || (busy_q[gi] && !clr_mask[gi]);
    end
  end

  // A writeback this cycle already releases its register for the head.
  assign busy_eff = busy_q & ~clr_mask;
  assign stall    = (dec.uses_rs1 && busy_eff[dec.rs1]) ||
                    (dec.uses_rs2 && busy_eff[dec.rs2]);

  always_ff @(posedge clk_i) begin
    if (rst_i) busy_q <= '0;
    else       busy_q <= busy_d;
  end
`else
  logic unused_wb;
  assign unused_wb = ^{wb_valid_i, wb_rd_i};
  assign stall     = 1'b0;
`endif

  // Head advances when the output slot is free or draining this cycle.
  assign load = !fifo_empty && (!valid_q || decode_ready_i) && !stall && !flush_i;

  always_comb begin
    valid_d  = valid_q;
    decode_d = decode_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (load) begin
      valid_d  = 1'b1;
      decode_d = dec;
    end else if (valid_q && decode_ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q  <= 1'b0;
      decode_q <= '0;
    end else begin
      valid_q  <= valid_d;
      decode_q <= decode_d;
    end
  end

  assign decode_valid_o = valid_q;
  assign decode_o       = decode_q;

endmodule

// File: tb/tb_id_decode_pipe.sv
module tb_id_decode_pipe;
  import pa_pkg::*;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        u1;
    logic        u2;
    logic        wr;
    logic        ill;
  } exp_t;

  logic      clk = 1'b0;
  logic      rst = 1'b1;
  logic      fetch_valid = 1'b0;
  logic      fetch_ready;
  if_stage_t fetch_d = '0;
  logic      decode_valid;
  logic      decode_ready = 1'b0;
  id_stage_t decode_q;
  logic      flush = 1'b0;
  logic      wb_valid = 1'b0;
  logic [4:0] wb_rd = 5'd0;

  int checks = 0;
  int failures = 0;
  int cycle = 0;
  logic [31:0] next_pc = 32'h100;
  exp_t exp_q[$];
  int acc_cyc[$];

  id_decode_pipe dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .fetch_valid_i  (fetch_valid),
    .fetch_ready_o  (fetch_ready),
    .fetch_i        (fetch_d),
    .decode_valid_o (decode_valid),
    .decode_ready_i (decode_ready),
    .decode_o       (decode_q),
    .flush_i        (flush),
    .wb_valid_i     (wb_valid),
    .wb_rd_i        (wb_rd)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cycle++;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end else begin
      $display("ok   %s = %h", name, act);
    end
  endtask

  // Monitor: pops one expectation per accepted output beat.
  initial forever begin
    exp_t e, a;
    @(negedge clk);
    if (!rst && decode_valid && decode_ready) begin
      a = '{pc: decode_q.pc, imm: decode_q.imm, rd: decode_q.rd, rs1: decode_q.rs1,
            rs2: decode_q.rs2, u1: decode_q.uses_rs1, u2: decode_q.uses_rs2,
            wr: decode_q.writes_rd, ill: decode_q.illegal};
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL out_unexpected actual=%h required=<none>", a);
      end else begin
        e = exp_q.pop_front();
        if (a !== e) begin
          failures++;
          $display("FAIL out_pc%h actual=%h required=%h", e.pc, a, e);
        end else begin
          $display("out  pc=%h imm=%h rd=%0d ill=%0b", a.pc, a.imm, a.rd, a.ill);
        end
      end
      acc_cyc.push_back(cycle);
    end
  end

  task automatic push(input logic [31:0] instr, input logic [31:0] imm,
                      input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic u1, input logic u2, input logic wr, input logic ill,
                      input bit track);
    bit ok = 0;
    fetch_d.pc    = next_pc;
    fetch_d.instr = instr;
    fetch_valid   = 1'b1;
    for (int n = 0; n < 50 && !ok; n++) begin
      @(negedge clk);
      if (fetch_ready) ok = 1;
      @(posedge clk);
      #1;
    end
    fetch_valid = 1'b0;
    if (!ok) chk("push_timeout", 64'd0, 64'd1);
    else if (track)
      exp_q.push_back('{pc: next_pc, imm: imm, rd: rd, rs1: rs1, rs2: rs2,
                        u1: u1, u2: u2, wr: wr, ill: ill});
    next_pc = next_pc + 32'd4;
  endtask

  task automatic drain();
    for (int n = 0; n < 100 && (exp_q.size() != 0 || decode_valid); n++) begin
      @(posedge clk);
      #1;
    end
    chk("drain_queue", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int na;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_valid", 64'(decode_valid), 64'd0);
    chk("rst_ready", 64'(fetch_ready), 64'd1);
    chk("rst_decode_zero", 64'(decode_q == '0), 64'd1);

    // ADDI x5,x0,-1: two-cycle latency.
    decode_ready = 1'b1;
    push(32'hFFF00293, 32'hFFFFFFFF, 5'd5, 5'd0, 5'd31, 1, 0, 1, 0, 1);
    chk("lat_e0_valid", 64'(decode_valid), 64'd0);
    @(posedge clk); #1;
    chk("lat_e1_valid", 64'(decode_valid), 64'd1);
    drain();

    // JAL x1,+2048 then BEQ -4, back to back.
    na = acc_cyc.size();
    push(32'h001000EF, 32'h00000800, 5'd1, 5'd0, 5'd1, 0, 0, 1, 0, 1);
    push(32'hFE000EE3, 32'hFFFFFFFC, 5'd29, 5'd0, 5'd0, 1, 1, 0, 0, 1);
    drain();
    chk("b2b_count", 64'(acc_cyc.size() - na), 64'd2);
    if (acc_cyc.size() >= na + 2)
      chk("b2b_gap", 64'(acc_cyc[na+1] - acc_cyc[na]), 64'd1);

    // Backpressure: three pushes into a 2-deep FIFO plus output register.
    decode_ready = 1'b0;
    push(32'h00500313, 32'h00000005, 5'd6, 5'd0, 5'd5, 1, 0, 1, 0, 1);
    push(32'h123453B7, 32'h12345000, 5'd7, 5'd8, 5'd3, 0, 0, 1, 0, 1);
    push(32'hFFFFF417, 32'hFFFFF000, 5'd8, 5'd31, 5'd31, 0, 0, 1, 0, 1);
    chk("full_ready_low", 64'(fetch_ready), 64'd0);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk("hold_valid", 64'(decode_valid), 64'd1);
      chk("hold_imm", 64'(decode_q.imm), 64'd5);
    end
    decode_ready = 1'b1;
    drain();

    // NOP (rd=x0 => no write), unknown opcode, bad low bits.
    push(32'h00000013, 32'h00000000, 5'd0, 5'd0, 5'd0, 1, 0, 0, 0, 1);
    push(32'h0000007F, 32'h00000000, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 1);
    push(32'hFFF00290, 32'h00000000, 5'd5, 5'd0, 5'd31, 0, 0, 0, 1, 1);
    drain();

    // Flush with full FIFO, loaded output and a concurrent push attempt.
    decode_ready = 1'b0;
    push(32'h00100493, 32'h1, 5'd9, 5'd0, 5'd1, 1, 0, 1, 0, 0);
    push(32'h00100493, 32'h1, 5'd9, 5'd0, 5'd1, 1, 0, 1, 0, 0);
    push(32'h00100493, 32'h1, 5'd9, 5'd0, 5'd1, 1, 0, 1, 0, 0);
    chk("preflush_ready", 64'(fetch_ready), 64'd0);
    flush = 1'b1;
    fetch_valid = 1'b1;
    fetch_d.instr = 32'hFE002C23;
    @(posedge clk); #1;
    flush = 1'b0;
    fetch_valid = 1'b0;
    chk("flush_valid", 64'(decode_valid), 64'd0);
    chk("flush_ready", 64'(fetch_ready), 64'd1);
    decode_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk("flush_no_out", 64'(decode_valid), 64'd0);
    end
    // SW x0,-8(x0) after flush.
    push(32'hFE002C23, 32'hFFFFFFF8, 5'd24, 5'd0, 5'd0, 1, 1, 0, 0, 1);
    drain();

`ifdef ID_SCOREBOARD_EN
    // ADDI x3,x0,1 then ADD x4,x3,x3: held until writeback of x3.
    na = acc_cyc.size();
    push(32'h00100193, 32'h00000001, 5'd3, 5'd0, 5'd1, 1, 0, 1, 0, 1);
    push(32'h00318233, 32'h00000000, 5'd4, 5'd3, 5'd3, 1, 1, 1, 0, 1);
    repeat (4) begin @(posedge clk); #1; end
    chk("stall_valid", 64'(decode_valid), 64'd0);
    chk("stall_one_out", 64'(acc_cyc.size() - na), 64'd1);
    wb_valid = 1'b1;
    wb_rd = 5'd3;
    @(posedge clk); #1;
    wb_valid = 1'b0;
    chk("issue_on_wb", 64'(decode_valid), 64'd1);
    drain();
`endif

    chk("final_queue_empty", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/id_decode_pipe.md
# id_decode_pipe

Pipelined, parametrised instruction decode stage for the pa simple CPU; successor to the single-cycle combinational decoder. Sits between fetch and execute. Buffers fetched instructions in a small FIFO, generates immediates and register/control fields, and presents them through a registered valid/ready output. Optionally stalls on read-after-write hazards with a register scoreboard.

## Interface
Parameters:
- XLEN, 32, datapath/immediate width; sign extension fills to XLEN.
- FIFO_DEPTH, 2, instruction buffer entries; power of two, ≥2.
- NUM_REGS, 32, architectural registers tracked by the scoreboard.

Ports:
- clk_i  in  1  clock; single clock domain.
- rst_i  in  1  reset, synchronous, active-high.
- fetch_valid_i  in  1  fetch beat valid.
- fetch_ready_o  out  1  FIFO can accept a beat.
- fetch_i  in  if_stage_t  pc and 32-bit instr.
- decode_valid_o  out  1  decode_o holds a valid decoded instruction.
- decode_ready_i  in  1  execute accepts decode_o.
- decode_o  out  id_stage_t  pc, imm[XLEN], rs1, rs2, rd, opcode, funct3, funct7, uses_rs1, uses_rs2, writes_rd, illegal.
- flush_i  in  1  discard all buffered and output-registered instructions.
- wb_valid_i  in  1  writeback retiring a register write.
- wb_rd_i  in  $clog2(NUM_REGS)  register written back.

## Operation
- Accept: a beat transfers when fetch_valid_i && fetch_ready_o at a rising edge; it is pushed to the FIFO tail.
- fetch_ready_o = FIFO not full. It is registered: deasserts in the cycle after the push that fills the FIFO. No push occurs when the FIFO is full.
- Decode is combinational on the FIFO head:
  - LUI/AUIPC take a U immediate.
  - JAL takes a J immediate.
  - IMM/LOAD/JALR take an I immediate.
  - STORE takes an S immediate.
  - BRANCH takes a B immediate.
  - B and J immediates have bit 0 = 0.
  - All immediates are sign-extended from instr[31] to XLEN, except U: instr[31:12] << 12, sign-extended above bit 31.
- Unknown opcode, or instr[1:0] != 2'b11: illegal=1, imm=0, writes_rd=0, uses_rs*=0. Illegal instructions still flow to execute.
- writes_rd=1 for LUI, AUIPC, JAL, JALR, LOAD, IMM, OP when rd != 0.
- Output register load: the head is popped and loaded into decode_o when the output register is empty or being consumed (decode_valid_o && decode_ready_i), and no hazard stall is active.
- Output register hold: while decode_valid_o && !decode_ready_i, decode_o and decode_valid_o are held stable.
- flush_i (takes priority over every other event):
  - Next edge empties the FIFO and clears decode_valid_o.
  - A simultaneous push is dropped.
  - The scoreboard is unaffected.
- Reset values:
  - decode_valid_o=0, decode_o=0.
  - fetch_ready_o=1 in the first cycle after reset.
  - FIFO pointers=0, scoreboard all clear.
  - Reset mid-transfer discards everything.

## Timing
- Latency: accept at edge E → FIFO; head loaded to output at edge E+1 → decode_valid_o high in cycle after E+1 (2 cycles).
- Throughput: 1 instruction/cycle with decode_ready_i held high and no hazards.
- Push and pop in the same cycle are allowed at any occupancy below full. At full, only pop occurs; ready rises the next cycle.
- Pointers wrap modulo FIFO_DEPTH. Full/empty are distinguished by an extra pointer bit.

## Configuration
- ID_SCOREBOARD_EN defined:
  - NUM_REGS busy bits. A bit is set when an instruction with writes_rd is loaded into the output register; it is cleared on wb_valid_i for wb_rd_i.
  - Same-cycle set and clear of the same register: set wins.
  - The head stalls while (uses_rs1 && busy[rs1]) || (uses_rs2 && busy[rs2]). The check uses busy & ~clear_this_cycle, so a same-cycle writeback releases the stall.
  - x0 is never busy.
- ID_SCOREBOARD_EN undefined: no busy bits, no stalls; wb_valid_i and wb_rd_i are ignored.

## Structure
- pa_pkg holds:
  - if_stage_t and id_stage_t, extended with uses_rs1, uses_rs2, writes_rd and illegal.
  - The imm_sel_e enum.
- riscv_pkg holds the opcode constants and the instruction-format unions.
- One sub-module: id_fifo, a parametrised synchronous FIFO with push/pop/flush. Immediate generation and the scoreboard stay in the top module.

## Test plan
- Reset, then push ADDI x5,x0,-1 (0xFFF00293) at PC 0x100 with ready high → decode_valid_o high 2 cycles later; imm=0xFFFFFFFF, rd=5, writes_rd=1, illegal=0.
- Push JAL x1,+2048 (0x001000EF), then BEQ with offset -4 (0xFE000EE3) → imm=0x00000800, then imm=0xFFFFFFFC; back-to-back output, 1/cycle.
- Hold decode_ready_i=0 while pushing 3 instructions with FIFO_DEPTH=2 → fetch_ready_o drops after the FIFO fills; decode_o stays stable. Release → all 3 emerge in order; none lost or duplicated.
- Two instructions buffered plus one in the output register, then flush_i for 1 cycle with a concurrent push → decode_valid_o=0 next cycle; FIFO empty; the pushed beat is dropped.
- ID_SCOREBOARD_EN: ADDI x3 then ADD x4,x3,x3 → ADD held until wb_valid_i with wb_rd_i=3, and issues the same cycle wb_valid_i is seen. Opcode 0x7F → illegal=1, imm=0.
